// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port among NUM_REQ requesters,
// one outstanding access at a time, with a per-access timeout error response.
module mem_arbiter #(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [NUM_REQ-1:0]               rsp_valid,
  input  logic [NUM_REQ-1:0]               rsp_ready,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_err,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic                             mem_read,
  output logic                             mem_write,
  output logic [DATA_WIDTH-1:0]            mem_wdata,
  input  logic [DATA_WIDTH-1:0]            mem_rdata,
  input  logic                             mem_ready,
  output logic                             busy
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                  state;
  logic [IDX_W-1:0]        rr_ptr;
  logic [IDX_W-1:0]        id;
  logic                    wr;
  logic [CNT_W-1:0]        cnt;
  logic                    found;
  logic [IDX_W-1:0]        win;
  logic [IDX_W-1:0]        cand;
  logic [ADDR_WIDTH-1:0]   addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0]   wdata_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin winner: first valid requester after rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((32'(rr_ptr) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign req_ready = (state == IDLE && reset_n && found) ? (NUM_REQ'(1) << win) : '0;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      rr_ptr    <= LAST_IDX;
      id        <= '0;
      wr        <= 1'b0;
      cnt       <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            id        <= win;
            wr        <= req_write[win];
            mem_addr  <= addr_arr[win];
            mem_wdata <= wdata_arr[win];
            mem_read  <= !req_write[win];
            mem_write <= req_write[win];
            cnt       <= '0;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          // Completion wins over a timeout landing in the same cycle.
          if (mem_ready) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            rsp_rdata <= wr ? '0 : mem_rdata;
            rsp_err   <= 1'b0;
            rsp_valid <= NUM_REQ'(1) << id;
            state     <= RESP;
          end else if (TIMEOUT != 0 && cnt == CNT_LAST) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= NUM_REQ'(1) << id;
            state     <= RESP;
          end else if (cnt != '1) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready[id]) begin
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            rr_ptr    <= id;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: transaction-level model drives requests and memory,
// a scoreboard queue holds expected responses checked by an independent monitor.
module tb_mem_arbiter;
  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [N-1:0]         req_valid, req_write, req_ready, rsp_valid, rsp_ready;
  logic [N-1:0][AW-1:0] req_addr;
  logic [N-1:0][DW-1:0] req_wdata;
  logic [DW-1:0]        rsp_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0]        mem_addr;
  logic                 rsp_err, mem_read, mem_write, mem_ready, busy;

  always #5 clk = ~clk;

  mem_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
  );

  typedef struct {
    int            id;
    logic [DW-1:0] rdata;
    logic          err;
  } rsp_t;

  rsp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (last + k) % N;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  // Transaction-level view: accept edge T, mem_ready at edge T+L (or timeout at T+TO),
  // handshake edge H chosen by the bench.
  bit            tx_act;
  int            tx_id, tx_T, tx_L, tx_E, tx_H, last_id, c, acc_id;
  bit            tx_w, stall;
  logic [AW-1:0] tx_addr;
  logic [DW-1:0] tx_wdata, tx_data;

  task automatic step(input bit quiesce);
    bit in_acc, in_rsp;
    int nxt, p;
    @(negedge clk);
    c++;
    if (tx_act && tx_H == c) begin
      tx_act  = 1'b0;
      last_id = tx_id;
    end
    in_acc = tx_act && c >= tx_T && c < tx_T + tx_E;
    in_rsp = tx_act && c >= tx_T + tx_E;
    check("mem_read", 64'(mem_read), 64'(in_acc && !tx_w));
    check("mem_write", 64'(mem_write), 64'(in_acc && tx_w));
    check("busy", 64'(busy), 64'(tx_act));
    check("rsp_valid_timing", 64'(rsp_valid), in_rsp ? 64'(oh(tx_id)) : 64'(0));
    if (in_acc) begin
      check("mem_addr", 64'(mem_addr), 64'(tx_addr));
      check("mem_wdata", 64'(mem_wdata), 64'(tx_wdata));
    end

    if (acc_id >= 0) begin
      req_valid[acc_id] = 1'b0;
      acc_id = -1;
    end
    if (!quiesce) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          req_valid[i] = 1'b1;
          req_write[i] = 1'($urandom_range(0, 1));
          req_addr[i]  = $urandom;
          req_wdata[i] = $urandom;
        end
      end
    end
    rsp_ready = N'($urandom);
    if (quiesce) rsp_ready = '1;
    else if (in_rsp)
      rsp_ready[tx_id] = stall ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 2) != 0);
    if (in_rsp && rsp_ready[tx_id]) tx_H = c + 1;

    nxt = c + 1;
    if (tx_act && nxt >= tx_T + 1 && nxt <= tx_T + tx_E) begin
      mem_ready = (tx_L <= TO) && (nxt == tx_T + tx_L);
      mem_rdata = mem_ready ? tx_data : DW'($urandom);
    end else begin
      mem_ready = ($urandom_range(0, 3) == 0);
      mem_rdata = $urandom;
    end

    #1;
    p = tx_act ? -1 : rr_pick(req_valid, last_id);
    check("req_ready", 64'(req_ready), (p >= 0) ? 64'(oh(p)) : 64'(0));
    if (p >= 0) begin
      tx_act   = 1'b1;
      tx_id    = p;
      tx_w     = req_write[p];
      tx_addr  = req_addr[p];
      tx_wdata = req_wdata[p];
      tx_T     = c + 1;
      tx_L     = $urandom_range(1, 6);
      tx_E     = (tx_L <= TO) ? tx_L : TO;
      tx_H     = -1;
      tx_data  = $urandom;
      stall    = ($urandom_range(0, 3) == 0);
      acc_id   = p;
      exp_q.push_back('{id: p, rdata: (tx_L <= TO && !tx_w) ? tx_data : DW'(0), err: (tx_L > TO)});
    end
  endtask

  // Response monitor: compares every presented response against the scoreboard head.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rsp_valid != '0) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 64'(rsp_valid), 64'(0));
        end else begin
          e = exp_q[0];
          check("rsp_id", 64'(rsp_valid), 64'(oh(e.id)));
          check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
          check("rsp_err", 64'(rsp_err), 64'(e.err));
          if (rsp_valid[e.id] && rsp_ready[e.id]) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    reset_n   = 1'b0;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = '0;
    mem_rdata = '0;
    mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mem_read", 64'(mem_read), 64'(0));
    check("rst_mem_write", 64'(mem_write), 64'(0));
    check("rst_mem_addr", 64'(mem_addr), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
    check("rst_rsp_err", 64'(rsp_err), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    reset_n = 1'b1;
    tx_act  = 1'b0;
    last_id = N - 1;
    c       = 0;
    acc_id  = -1;
    repeat (3000) step(1'b0);
    repeat (60) step(1'b1);

    // Reset in the middle of a read abandons it; requester 0 wins first afterwards.
    @(negedge clk);
    mem_ready    = 1'b0;
    rsp_ready    = '1;
    req_valid    = 3'b001;
    req_write[0] = 1'b0;
    req_addr[0]  = 32'h100;
    #1;
    check("pre_rst_grant", 64'(req_ready), 64'(3'b001));
    @(negedge clk);
    check("pre_rst_read", 64'(mem_read), 64'(1));
    check("pre_rst_addr", 64'(mem_addr), 64'(32'h100));
    #3;
    reset_n = 1'b0;
    #1;
    check("mid_rst_read", 64'(mem_read), 64'(0));
    check("mid_rst_addr", 64'(mem_addr), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_req_ready", 64'(req_ready), 64'(0));
    @(negedge clk);
    req_valid    = 3'b011;
    req_write[1] = 1'b1;
    req_addr[1]  = 32'h200;
    reset_n      = 1'b1;
    #1;
    check("post_rst_grant", 64'(req_ready), 64'(3'b001));
    exp_q.push_back('{id: 0, rdata: 32'hDEADBEEF, err: 1'b0});
    @(negedge clk);
    req_valid = '0;
    check("post_rst_read", 64'(mem_read), 64'(1));
    check("post_rst_addr", 64'(mem_addr), 64'(32'h100));
    mem_ready = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    mem_ready = 1'b0;
    check("post_rst_rsp", 64'(rsp_valid), 64'(3'b001));
    repeat (4) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
